// File: rtl/pipelined_adder_pkg.sv
// Shared types and sizing helpers for the chunked pipelined adder.
package pipelined_adder_pkg;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'd0,
    MODE_SUB  = 2'd1,
    MODE_ADC  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 8;

  // WIDTH must be an exact multiple of CHUNK; one register stage per chunk.
  function automatic int num_stages(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result valid-ready bundle; names are as seen from the adder (slave) side.
interface pipelined_adder_if
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             carry_i;
  mode_e            mode_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] sum_o;
  logic             carry_o;
  logic             overflow_o;
  logic             zero_o;

  modport slave (
    input  valid_i, a_i, b_i, carry_i, mode_i, ready_i,
    output ready_o, valid_o, sum_o, carry_o, overflow_o, zero_o
  );

  modport master (
    output valid_i, a_i, b_i, carry_i, mode_i, ready_i,
    input  ready_o, valid_o, sum_o, carry_o, overflow_o, zero_o
  );
endinterface

// File: rtl/pipelined_adder_chunk.sv
// Combinational CHUNK-bit adder slice; cmsb_o is the carry into the top bit for overflow.
module pipelined_adder_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o,
  output logic             cmsb_o
);
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};
  assign cmsb_o          = sum_o[CHUNK-1] ^ a_i[CHUNK-1] ^ b_i[CHUNK-1];
endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/sub/adc split into WIDTH/CHUNK registered chunk stages; latency STAGES.
// Whole pipe advances only when the output is empty or taken, so a stalled result holds input off.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input logic              clk_i,
  input logic              rst_i,
  pipelined_adder_if.slave bus
);
  localparam int STAGES = num_stages(WIDTH, CHUNK);

  typedef logic [WIDTH-1:0] word_t;

  logic  adv;
  word_t b_eff;
  logic  cin;

  // op_* are the values entering stage k: the prepared input for k=0, else stage k-1's registers.
  logic  op_v [STAGES];
  word_t op_a [STAGES];
  word_t op_b [STAGES];
  logic  op_c [STAGES];
  word_t op_s [STAGES];

  logic [CHUNK-1:0] chunk_s  [STAGES];
  logic             chunk_co [STAGES];
  logic             chunk_cm [STAGES];
  word_t            s_d      [STAGES];

  logic  vld_q [STAGES];
  word_t a_q   [STAGES];
  word_t b_q   [STAGES];
  logic  c_q   [STAGES];
  word_t s_q   [STAGES];
  logic  ovf_q;
  logic  zero_q;

  assign adv = !vld_q[STAGES-1] || bus.ready_i;

  always_comb begin
    b_eff = bus.b_i;
    cin   = 1'b0;
    case (bus.mode_i)
      MODE_SUB: begin
        b_eff = ~bus.b_i;
        cin   = 1'b1;
      end
      MODE_ADC: cin = bus.carry_i;
      default:  ;
    endcase
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign op_v[k] = bus.valid_i;
      assign op_a[k] = bus.a_i;
      assign op_b[k] = b_eff;
      assign op_c[k] = cin;
      assign op_s[k] = '0;
    end else begin : g_body
      assign op_v[k] = vld_q[k-1];
      assign op_a[k] = a_q[k-1];
      assign op_b[k] = b_q[k-1];
      assign op_c[k] = c_q[k-1];
      assign op_s[k] = s_q[k-1];
    end

    pipelined_adder_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a_i    (op_a[k][k*CHUNK +: CHUNK]),
      .b_i    (op_b[k][k*CHUNK +: CHUNK]),
      .cin_i  (op_c[k]),
      .sum_o  (chunk_s[k]),
      .cout_o (chunk_co[k]),
      .cmsb_o (chunk_cm[k])
    );

    // Lower chunks ride along already computed; upper bits of op_s are still zero here.
    assign s_d[k] = op_s[k] | (word_t'(chunk_s[k]) << (k*CHUNK));
  end

  // Data registers load only behind a valid op so the outputs keep their last result through bubbles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        c_q[k]   <= 1'b0;
        s_q[k]   <= '0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= op_v[k];
        if (op_v[k]) begin
          a_q[k] <= op_a[k];
          b_q[k] <= op_b[k];
          c_q[k] <= chunk_co[k];
          s_q[k] <= s_d[k];
        end
      end
      if (op_v[STAGES-1]) begin
        ovf_q  <= chunk_cm[STAGES-1] ^ chunk_co[STAGES-1];
        zero_q <= ~|s_d[STAGES-1];
      end
    end
  end

  assign bus.ready_o    = adv;
  assign bus.valid_o    = vld_q[STAGES-1];
  assign bus.sum_o      = s_q[STAGES-1];
  assign bus.carry_o    = c_q[STAGES-1];
  assign bus.overflow_o = ovf_q;
  assign bus.zero_o     = zero_q;
endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder at WIDTH=32, CHUNK=8 (latency 4).
module tb_pipelined_adder;
  import pipelined_adder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(32)) bus ();

  pipelined_adder #(.WIDTH(32), .CHUNK(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [34:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic ci, input mode_e m);
    logic [32:0] t;
    logic [31:0] be;
    logic        c0;
    logic        v;
    be = (m == MODE_SUB) ? ~b : b;
    c0 = (m == MODE_SUB) ? 1'b1 : (m == MODE_ADC) ? ci : 1'b0;
    t  = {1'b0, a} + {1'b0, be} + {32'b0, c0};
    v  = (a[31] == be[31]) && (t[31] != a[31]);
    return {t[32], v, (t[31:0] == 32'd0), t[31:0]};
  endfunction

  function automatic logic [34:0] dut_result();
    return {bus.carry_o, bus.overflow_o, bus.zero_o, bus.sum_o};
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic ci, input mode_e m);
    bus.valid_i = 1'b1;
    bus.a_i     = a;
    bus.b_i     = b;
    bus.carry_i = ci;
    bus.mode_i  = m;
  endtask

  // flags packed as {carry, overflow, zero}
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic ci, input mode_e m,
                        input logic [31:0] exp_sum, input logic [2:0] exp_flags);
    int lat;
    bus.ready_i = 1'b1;
    drive(a, b, ci, m);
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    lat = 1;
    while (!bus.valid_o && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".lat"}, 64'(lat), 64'd4);
    check({tag, ".sum"}, 64'(bus.sum_o), 64'(exp_sum));
    check({tag, ".flags"}, 64'({bus.carry_o, bus.overflow_o, bus.zero_o}), 64'(exp_flags));
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra [8];
    logic [31:0] rb [8];
    logic        rc [8];
    mode_e       rm [8];
    logic [34:0] exp_q [$];
    logic [34:0] exp_r;
    logic [31:0] prev_sum;
    logic        prev_stall;
    int          sent, got, stalls, stale;

    bus.valid_i = 1'b0;
    bus.a_i     = '0;
    bus.b_i     = '0;
    bus.carry_i = 1'b0;
    bus.mode_i  = MODE_ADD;
    bus.ready_i = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("reset.valid", 64'(bus.valid_o), 64'd0);
    check("reset.sum", 64'(bus.sum_o), 64'd0);
    check("reset.flags", 64'({bus.carry_o, bus.overflow_o, bus.zero_o}), 64'd0);
    check("reset.ready", 64'(bus.ready_o), 64'd1);
    rst = 1'b0;

    run_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, MODE_ADD, 32'h0000_0000, 3'b101);
    run_op("add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, MODE_ADD, 32'h8000_0000, 3'b010);
    run_op("sub_neg",  32'd5, 32'd7, 1'b0, MODE_SUB, 32'hFFFF_FFFE, 3'b000);
    run_op("sub_pos",  32'd7, 32'd5, 1'b0, MODE_SUB, 32'h0000_0002, 3'b100);
    run_op("adc_cross", 32'h0000_00FF, 32'h0000_0000, 1'b1, MODE_ADC, 32'h0000_0100, 3'b000);
    run_op("rsvd_add", 32'h0000_0010, 32'h0000_0020, 1'b1, MODE_RSVD, 32'h0000_0030, 3'b000);
    run_op("add_nocin", 32'd1, 32'd1, 1'b1, MODE_ADD, 32'd2, 3'b000);
    run_op("sub_ovf",  32'h8000_0000, 32'h0000_0001, 1'b0, MODE_SUB, 32'h7FFF_FFFF, 3'b110);
    run_op("sub_zero", 32'h0000_1234, 32'h0000_1234, 1'b0, MODE_SUB, 32'h0000_0000, 3'b101);

    // Back-to-back stream with the consumer stalling in cycles 6..8.
    for (int i = 0; i < 8; i++) begin
      ra[i] = $urandom();
      rb[i] = $urandom();
      rc[i] = 1'($urandom_range(0, 1));
      rm[i] = mode_e'($urandom_range(0, 3));
      exp_q.push_back(ref_model(ra[i], rb[i], rc[i], rm[i]));
    end
    sent = 0; got = 0; stalls = 0; prev_stall = 1'b0; prev_sum = '0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      bus.ready_i = !(cyc >= 6 && cyc <= 8);
      if (sent < 8) drive(ra[sent], rb[sent], rc[sent], rm[sent]);
      else bus.valid_i = 1'b0;
      #3;
      check("stream.ready", 64'(bus.ready_o), 64'(!(bus.valid_o && !bus.ready_i)));
      if (prev_stall) check("stream.hold", 64'(bus.sum_o), 64'(prev_sum));
      if (bus.valid_o && bus.ready_i) begin
        if (exp_q.size() == 0) begin
          check("stream.extra", 64'd1, 64'd0);
        end else begin
          exp_r = exp_q.pop_front();
          check("stream.result", 64'(dut_result()), 64'(exp_r));
        end
        got++;
      end
      if (bus.valid_o && !bus.ready_i) stalls++;
      prev_stall = bus.valid_o && !bus.ready_i;
      prev_sum   = bus.sum_o;
      if (bus.valid_i && bus.ready_o) sent++;
      @(posedge clk); #1;
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    check("stream.count", 64'(got), 64'd8);
    check("stream.stalls", 64'(stalls), 64'd3);

    // Three ops in flight, then a one-cycle reset on the edge the first would have emerged.
    for (int i = 0; i < 3; i++) begin
      drive(32'h0101_0101 * (i + 1), 32'h0000_0003, 1'b0, MODE_ADD);
      @(posedge clk); #1;
    end
    bus.valid_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst.valid", 64'(bus.valid_o), 64'd0);
    check("rst.sum", 64'(bus.sum_o), 64'd0);
    check("rst.flags", 64'({bus.carry_o, bus.overflow_o, bus.zero_o}), 64'd0);
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.valid_o) stale++;
      @(posedge clk); #1;
    end
    check("rst.stale", 64'(stale), 64'd0);
    run_op("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, MODE_ADD, 32'h2345_6789, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
